vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The module SHALL use parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The module SHALL use parameter V_ACTIVE, default 600, visible lines per frame.
REQ-003 The module SHALL use parameter FB_W, default 200, framebuffer words per line (4x horizontal scale).
REQ-004 The module SHALL use parameter FB_DEPTH, default 30000, framebuffer words (200x150).
REQ-005 The module SHALL use parameter WR1_VBLANK_ONLY, default 1; when 1, writer 1 is eligible only while vcount >= V_ACTIVE.
REQ-006 The module SHALL have these ports; one clock, reset is synchronous and active-high:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- pxl_tick  in  1  one-cycle pulse per pixel (every 2nd clk).
- hcount  in  11  current pixel column from panel timing.
- vcount  in  11  current line from panel timing.
- wr0_valid, wr1_valid  in  1  write requests.
- wr0_ready, wr1_ready  out  1  write accepted this cycle.
- wr0_addr, wr1_addr  in  15  word address.
- wr0_data, wr1_data  in  12  RGB444 word.
- mem_en, mem_we  out  1  RAM port enable / write enable.
- mem_addr  out  15  RAM address.
- mem_wdata  out  12  RAM write data.
- mem_rdata  in  12  RAM read data, valid 1 clk after a read.
- red, green, blue  out  4  pixel colour.
- wr_err  out  1  one-cycle pulse: out-of-range write dropped.

Function
REQ-007 A cycle SHALL be a display slot iff pxl_tick=1, hcount<H_ACTIVE, vcount<V_ACTIVE and hcount[1:0]=0; every other cycle is a write slot.
REQ-008 In a display slot, mem_en=1, mem_we=0, mem_addr=(vcount>>2)*FB_W+(hcount>>2), computed by shifts/adds (v*200 = v<<7 + v<<6 + v<<3), 15-bit result; both wrN_ready=0.
REQ-009 mem_en, mem_we, mem_addr, mem_wdata and wrN_ready SHALL be combinational from current inputs and registered state.
REQ-010 A 2-stage pipeline SHALL track each pxl_tick: stage 1 records active and read-issued flags; stage 2 updates red/green/blue 2 clk after the tick.
REQ-011 For a tick with a read issued, rgb SHALL become mem_rdata[11:8], [7:4], [3:0]; for an active tick with hcount[1:0]!=0, rgb holds its value (pixel reuse); for an inactive tick, rgb SHALL become 0.
REQ-012 rgb SHALL change only 2 clk after a pxl_tick and otherwise hold.
REQ-013 In a write slot, eligible requesters: wr0 if wr0_valid; wr1 if wr1_valid and (WR1_VBLANK_ONLY=0 or vcount>=V_ACTIVE).
REQ-014 Round-robin FSM states PRI0, PRI1: with one eligible, it is granted; with both, PRI0 grants wr0, PRI1 grants wr1.
REQ-015 After a grant to wrN the FSM SHALL move to PRI(1-N); with no grant the state holds.
REQ-016 A grant SHALL assert wrN_ready=1 for exactly that cycle, with at most one ready per cycle.
REQ-017 A grant with addr<FB_DEPTH SHALL drive mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=data.
REQ-018 A grant with addr>=FB_DEPTH SHALL still assert ready but keep mem_en=0, and pulse wr_err=1 on the next cycle.
REQ-019 With no grant and no display slot, mem_en=0, mem_we=0, and mem_addr/mem_wdata=0.
REQ-020 Writers SHALL never be granted in a display slot, regardless of valid duration; the display is never stalled.

Reset
REQ-021 While rst=1: FSM=PRI0, pipeline flags=0, rgb=0, wr_err=0, and mem_en=0 and wrN_ready=0 regardless of inputs.
REQ-022 A read in flight when rst rises SHALL be discarded; its mem_rdata never reaches rgb.
REQ-023 The first cycle after reset release SHALL be arbitrated normally per REQ-007..REQ-020.

Structure
REQ-024 Package vga_pkg SHALL hold H_ACTIVE, V_ACTIVE, H_TOTAL=1040, V_TOTAL=666, FB_W, FB_H=150, FB_DEPTH and typedef rgb444_t (red, green, blue 4-bit fields).
REQ-025 The two-requester round-robin SHALL be sub-module vga_rr_arb2 (inputs: req[1:0], advance; outputs: gnt[1:0]); all remaining logic stays in vga_fb_arbiter.

Verification
REQ-026 Reset: rst=1 for 2 clk with wr0_valid=1 -> wr0_ready=0, mem_en=0, rgb=0; the first write slot after release grants wr0.
REQ-027 Display read: tick at h=8, v=4 -> mem_addr=202, mem_we=0, wrN_ready=0 that cycle; mem_rdata=12'hF0A next clk -> rgb=F,0,A 2 clk after the tick.
REQ-028 Round-robin: wr0 and wr1 valid continuously, WR1_VBLANK_ONLY=0, v=610 -> grants alternate wr0, wr1, wr0, wr1.
REQ-029 Vblank gating: wr1 only valid at v=100 -> wr1_ready stays 0; at v=600 -> granted in the first write slot.
REQ-030 Out-of-range: wr0_addr=30000 granted -> wr0_ready=1, mem_en=0, wr_err=1 the next clk only.
REQ-031 Blanking/reuse: tick at h=5 -> no read, rgb holds; tick at h=800 -> rgb=0 2 clk later.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, framebuffer geometry and types for the VGA framebuffer arbiter
package vga_pkg;

    localparam int H_ACTIVE = 800;   // visible pixels per line
    localparam int V_ACTIVE = 600;   // visible lines per frame
    localparam int H_TOTAL  = 1040;  // pixels per line including blanking
    localparam int V_TOTAL  = 666;   // lines per frame including blanking
    localparam int FB_W     = 200;   // framebuffer words per line (4x horizontal scale)
    localparam int FB_H     = 150;   // framebuffer lines (4x vertical scale)
    localparam int FB_DEPTH = FB_W * FB_H;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } rr_state_t;

endpackage

// File: rtl/vga_rr_arb2.sv
// rtl/vga_rr_arb2.sv - two-requester round-robin arbiter
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req[1:0]      eligible requesters this cycle
//   advance       arbitration allowed this cycle (write slot, not in reset)
//   gnt[1:0]      one-hot grant, combinational; zero when advance=0
module vga_rr_arb2
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    rr_state_t state_q;
    rr_state_t state_d;

    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        if (advance) begin
            if (req == 2'b11) begin
                gnt = (state_q == PRI0) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
            // The winner drops to lowest priority; an idle slot keeps the order.
            if (gnt[0]) state_d = PRI1;
            if (gnt[1]) state_d = PRI0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRI0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer RAM arbiter: display reads plus two round-robin writers
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   pxl_tick, hcount, vcount        pixel strobe and panel timing position
//   wrN_valid/ready/addr/data       writer request channels (RGB444 words)
//   mem_en/we/addr/wdata, mem_rdata RAM port (read data one clock after a read)
//   red, green, blue                pixel colour, updated two clocks after each pxl_tick
//   wr_err                          one-cycle pulse after an out-of-range write was dropped
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE        = vga_pkg::V_ACTIVE,
    parameter int FB_W            = vga_pkg::FB_W,
    parameter int FB_DEPTH        = vga_pkg::FB_DEPTH,
    parameter int WR1_VBLANK_ONLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_tick,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        wr0_valid,
    input  logic        wr1_valid,
    output logic        wr0_ready,
    output logic        wr1_ready,
    input  logic [14:0] wr0_addr,
    input  logic [14:0] wr1_addr,
    input  logic [11:0] wr0_data,
    input  logic [11:0] wr1_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        wr_err
);

    localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
    localparam logic [14:0] DEPTH_LIM = 15'(FB_DEPTH);

    logic        active;
    logic        disp_slot;
    logic        wr1_elig;
    logic        advance;
    logic        grant;
    logic        in_range;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [14:0] v_idx;
    logic [14:0] h_idx;
    logic [14:0] rd_row;
    logic [14:0] rd_addr;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;

    logic    s1_tick_q, s1_tick_d;
    logic    s1_act_q,  s1_act_d;
    logic    s1_rd_q,   s1_rd_d;
    logic    wr_err_q,  wr_err_d;
    rgb444_t rgb_q,     rgb_d;

    // Only every 4th visible pixel fetches a word; the other three reuse it,
    // which leaves those ticks and all non-tick cycles free for writers.
    assign active    = (hcount < H_LIM) && (vcount < V_LIM);
    assign disp_slot = pxl_tick && active && (hcount[1:0] == 2'b00);

    assign v_idx = {6'd0, vcount[10:2]};
    assign h_idx = {6'd0, hcount[10:2]};

    always_comb begin
        if (FB_W == 200) begin
            rd_row = (v_idx << 7) + (v_idx << 6) + (v_idx << 3);
        end else begin
            rd_row = 15'(v_idx * 15'(FB_W));
        end
    end
    assign rd_addr = rd_row + h_idx;

    assign wr1_elig = wr1_valid && ((WR1_VBLANK_ONLY == 0) || (vcount >= V_LIM));
    assign req      = {wr1_elig, wr0_valid};
    assign advance  = !rst && !disp_slot;

    vga_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    assign grant     = |gnt;
    assign wr_addr   = gnt[1] ? wr1_addr : wr0_addr;
    assign wr_data   = gnt[1] ? wr1_data : wr0_data;
    assign in_range  = wr_addr < DEPTH_LIM;
    assign wr0_ready = gnt[0];
    assign wr1_ready = gnt[1];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 15'd0;
        mem_wdata = 12'd0;
        if (!rst) begin
            if (disp_slot) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end else if (grant && in_range) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
        end
    end

    // Stage 1 remembers what the tick did; stage 2 lands the colour once RAM data is valid.
    always_comb begin
        s1_tick_d = pxl_tick;
        s1_act_d  = active;
        s1_rd_d   = disp_slot;
        wr_err_d  = grant && !in_range;
        rgb_d     = rgb_q;
        if (s1_tick_q) begin
            if (s1_rd_q) begin
                rgb_d = rgb444_t'(mem_rdata);
            end else if (!s1_act_q) begin
                rgb_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tick_q <= 1'b0;
            s1_act_q  <= 1'b0;
            s1_rd_q   <= 1'b0;
            wr_err_q  <= 1'b0;
            rgb_q     <= '0;
        end else begin
            s1_tick_q <= s1_tick_d;
            s1_act_q  <= s1_act_d;
            s1_rd_q   <= s1_rd_d;
            wr_err_q  <= wr_err_d;
            rgb_q     <= rgb_d;
        end
    end

    assign red    = rgb_q.red;
    assign green  = rgb_q.green;
    assign blue   = rgb_q.blue;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    logic        clk;
    logic        rst;
    logic        pxl_tick;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        wr0_valid;
    logic        wr1_valid;
    logic        wr0_ready;
    logic        wr1_ready;
    logic [14:0] wr0_addr;
    logic [14:0] wr1_addr;
    logic [11:0] wr0_data;
    logic [11:0] wr1_data;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        wr_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_tick  (pxl_tick),
        .hcount    (hcount),
        .vcount    (vcount),
        .wr0_valid (wr0_valid),
        .wr1_valid (wr1_valid),
        .wr0_ready (wr0_ready),
        .wr1_ready (wr1_ready),
        .wr0_addr  (wr0_addr),
        .wr1_addr  (wr1_addr),
        .wr0_data  (wr0_data),
        .wr1_data  (wr1_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .wr_err    (wr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        tick;
        logic [10:0] h;
        logic [10:0] v;
        logic        v0;
        logic        v1;
        logic [14:0] a0;
        logic [14:0] a1;
        logic [11:0] d0;
        logic [11:0] d1;
        logic        en;
        logic        we;
        logic [14:0] addr;
        logic [11:0] wd;
        logic        r0;
        logic        r1;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pxl_tick  = 1'b0;
        hcount    = 11'd0;
        vcount    = 11'd0;
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        wr0_addr  = 15'd0;
        wr1_addr  = 15'd0;
        wr0_data  = 12'd0;
        wr1_data  = 12'd0;
        mem_rdata = 12'd0;
    endtask

    task automatic chk_rgb(input string name, input logic [11:0] exp);
        chk(name, 32'({red, green, blue}), 32'(exp));
    endtask

    initial begin
        // tick, h, v, v0, v1, a0, a1, d0, d1 | en, we, addr, wdata, r0, r1, err
        tbl.push_back('{1'b1, 11'd8,   11'd4,   1'b1, 1'b0, 15'd5,     15'd0,  12'h111, 12'h000, 1'b1, 1'b0, 15'd202,   12'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 11'd8,   11'd4,   1'b1, 1'b0, 15'd5,     15'd0,  12'h111, 12'h000, 1'b1, 1'b1, 15'd5,     12'h111, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11'd12,  11'd8,   1'b1, 1'b0, 15'd7,     15'd0,  12'h444, 12'h000, 1'b1, 1'b0, 15'd403,   12'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 11'd12,  11'd8,   1'b0, 1'b1, 15'd0,     15'd9,  12'h000, 12'h555, 1'b0, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd610, 1'b1, 1'b1, 15'd10,    15'd11, 12'h333, 12'h222, 1'b1, 1'b1, 15'd11,    12'h222, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd610, 1'b1, 1'b1, 15'd10,    15'd11, 12'h333, 12'h222, 1'b1, 1'b1, 15'd10,    12'h333, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd610, 1'b1, 1'b1, 15'd10,    15'd11, 12'h333, 12'h222, 1'b1, 1'b1, 15'd11,    12'h222, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd610, 1'b1, 1'b1, 15'd10,    15'd11, 12'h333, 12'h222, 1'b1, 1'b1, 15'd10,    12'h333, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11'd796, 11'd599, 1'b1, 1'b0, 15'd12,    15'd0,  12'h777, 12'h000, 1'b1, 1'b0, 15'd29999, 12'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11'd800, 11'd0,   1'b1, 1'b0, 15'd29999, 15'd0,  12'hABC, 12'h000, 1'b1, 1'b1, 15'd29999, 12'hABC, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd0,   1'b1, 1'b0, 15'd30000, 15'd0,  12'hFFF, 12'h000, 1'b0, 1'b0, 15'd0,     12'h000, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd0,   1'b0, 1'b0, 15'd0,     15'd0,  12'h000, 12'h000, 1'b0, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 11'd0,   11'd0,   1'b0, 1'b0, 15'd0,     15'd0,  12'h000, 12'h000, 1'b0, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11'd0,   11'd600, 1'b0, 1'b1, 15'd0,     15'd20, 12'h000, 12'h0F0, 1'b1, 1'b1, 15'd20,    12'h0F0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 11'd0,   11'd600, 1'b1, 1'b1, 15'd21,    15'd22, 12'h0AA, 12'h0BB, 1'b1, 1'b1, 15'd21,    12'h0AA, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11'd799, 11'd10,  1'b1, 1'b0, 15'd100,   15'd0,  12'h123, 12'h000, 1'b1, 1'b1, 15'd100,   12'h123, 1'b1, 1'b0, 1'b0});

        // Reset with a pending writer and a display tick: nothing may leak out.
        clear_inputs();
        rst       = 1'b1;
        pxl_tick  = 1'b1;
        wr0_valid = 1'b1;
        wr0_addr  = 15'd3;
        wr0_data  = 12'h3C3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_wr0_ready", 32'(wr0_ready), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_wr_err", 32'(wr_err), 32'd0);
            chk_rgb("rst_rgb", 12'h000);
        end
        next_cycle();
        rst      = 1'b0;
        pxl_tick = 1'b0;
        @(negedge clk);
        chk("rel_wr0_ready", 32'(wr0_ready), 32'd1);
        chk("rel_mem_we", 32'(mem_we), 32'd1);
        chk("rel_mem_addr", 32'(mem_addr), 32'd3);

        // Fresh reset so the table starts from PRI0.
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            pxl_tick  = tbl[i].tick;
            hcount    = tbl[i].h;
            vcount    = tbl[i].v;
            wr0_valid = tbl[i].v0;
            wr1_valid = tbl[i].v1;
            wr0_addr  = tbl[i].a0;
            wr1_addr  = tbl[i].a1;
            wr0_data  = tbl[i].d0;
            wr1_data  = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].wd));
            chk($sformatf("v%0d_wr0_ready", i), 32'(wr0_ready), 32'(tbl[i].r0));
            chk($sformatf("v%0d_wr1_ready", i), 32'(wr1_ready), 32'(tbl[i].r1));
            chk($sformatf("v%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].err));
            next_cycle();
        end

        // Display read: data appears on rgb two clocks after the tick, not one.
        clear_inputs();
        pxl_tick = 1'b1;
        hcount   = 11'd8;
        vcount   = 11'd4;
        next_cycle();
        pxl_tick  = 1'b0;
        mem_rdata = 12'hF0A;
        @(negedge clk);
        chk_rgb("read_rgb_t1", 12'h000);
        next_cycle();
        mem_rdata = 12'h000;
        @(negedge clk);
        chk_rgb("read_rgb_t2", 12'hF0A);

        // Pixel reuse: active tick off the 4-pixel grid keeps the colour.
        next_cycle();
        pxl_tick = 1'b1;
        hcount   = 11'd5;
        next_cycle();
        pxl_tick  = 1'b0;
        mem_rdata = 12'h123;
        next_cycle();
        mem_rdata = 12'h000;
        @(negedge clk);
        chk_rgb("reuse_rgb", 12'hF0A);

        // Blanking: tick past the visible area blanks rgb, two clocks later.
        next_cycle();
        pxl_tick = 1'b1;
        hcount   = 11'd800;
        next_cycle();
        pxl_tick = 1'b0;
        @(negedge clk);
        chk_rgb("blank_rgb_t1", 12'hF0A);
        next_cycle();
        @(negedge clk);
        chk_rgb("blank_rgb_t2", 12'h000);

        // Load a known colour, then reset while a read is in flight.
        next_cycle();
        pxl_tick = 1'b1;
        hcount   = 11'd0;
        vcount   = 11'd0;
        next_cycle();
        pxl_tick  = 1'b0;
        mem_rdata = 12'h321;
        next_cycle();
        mem_rdata = 12'h000;
        @(negedge clk);
        chk_rgb("pre_rst_rgb", 12'h321);
        next_cycle();
        pxl_tick = 1'b1;
        hcount   = 11'd4;
        next_cycle();
        pxl_tick  = 1'b0;
        rst       = 1'b1;
        mem_rdata = 12'hFFF;
        next_cycle();
        rst       = 1'b0;
        mem_rdata = 12'h000;
        @(negedge clk);
        chk_rgb("inflight_rgb_t1", 12'h000);
        next_cycle();
        @(negedge clk);
        chk_rgb("inflight_rgb_t2", 12'h000);

        // A tick sampled while in reset must not be remembered after release.
        next_cycle();
        pxl_tick = 1'b1;
        hcount   = 11'd0;
        next_cycle();
        pxl_tick  = 1'b0;
        mem_rdata = 12'h456;
        next_cycle();
        mem_rdata = 12'h000;
        @(negedge clk);
        chk_rgb("reload_rgb", 12'h456);
        next_cycle();
        pxl_tick = 1'b1;
        hcount   = 11'd800;
        rst      = 1'b1;
        next_cycle();
        pxl_tick  = 1'b0;
        rst       = 1'b0;
        next_cycle();
        @(negedge clk);
        chk_rgb("rst_tick_rgb", 12'h000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
